// File: rtl/priority_scan_sequencer.sv
// Priority scanner: accepts a request vector, streams set-bit indices one per beat (max MAX_HITS).
// Latency: first beat valid the cycle after the input handshake; in_ready returns the cycle after the last beat.
// Backpressure: out_* held stable while out_ready is low; in_ready depends only on state. MSB-first order with PRIORITY_SCAN_MSB_FIRST_EN.
module priority_scan_sequencer #(
    parameter int INPUTS   = 12,
    parameter int MAX_HITS = 7,
    localparam int IDX_W   = $clog2(INPUTS),
    localparam int CNT_W   = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [CNT_W-1:0]  out_hit_num,
    output logic              out_last,
    output logic              out_none,
    output logic              out_overflow
);

    generate
        if (INPUTS < 2) begin : g_bad_inputs
            $error("priority_scan_sequencer: INPUTS must be >= 2");
        end
        if (MAX_HITS < 1 || MAX_HITS > INPUTS) begin : g_bad_max_hits
            $error("priority_scan_sequencer: MAX_HITS must be in 1..INPUTS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [INPUTS-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    pick_idx;
    logic [INPUTS-1:0]   pick_oh;
    logic                mask_empty;
    logic                mask_multi;
    logic                at_cap;
    logic                emit;
    logic                beat_last;

    // Last assignment in the loop wins, so the loop direction sets priority.
    always_comb begin
        pick_idx = '0;
        pick_oh  = '0;
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        for (int i = 0; i < INPUTS; i++) begin
            if (mask_q[i]) begin
                pick_idx   = IDX_W'(i);
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
`else
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                pick_idx   = IDX_W'(i);
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
`endif
    end

    // x & (x-1) is nonzero exactly when two or more bits are set.
    assign mask_empty = ~|mask_q;
    assign mask_multi = |(mask_q & (mask_q - INPUTS'(1)));
    assign at_cap     = (cnt_q == CNT_LAST);
    assign emit       = (state_q == EMIT);
    assign beat_last  = mask_empty || !mask_multi || at_cap;

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = emit;
    assign out_index    = emit ? pick_idx : '0;
    assign out_hit_num  = emit ? cnt_q : '0;
    assign out_last     = emit && beat_last;
    assign out_none     = emit && mask_empty;
    assign out_overflow = emit && at_cap && mask_multi;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d  = in_vec;
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (beat_last) begin
                        // Any bits left beyond the cap are dropped here.
                        mask_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        mask_d = mask_q & ~pick_oh;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                mask_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_sequencer.sv
// Directed bench for priority_scan_sequencer: expected beats are queued at stimulus time and checked by a monitor.
module tb_priority_scan_sequencer;

    localparam int INPUTS   = 12;
    localparam int MAX_HITS = 7;
    localparam int IDX_W    = $clog2(INPUTS);
    localparam int CNT_W    = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;

    logic              clk;
    logic              rst_n;
    logic [INPUTS-1:0] in_vec;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [CNT_W-1:0]  out_hit_num;
    logic              out_last;
    logic              out_none;
    logic              out_overflow;

    typedef struct {
        int idx;
        int num;
        int last;
        int none;
        int ovf;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  chk_ready_next = 1'b0;

    priority_scan_sequencer #(.INPUTS(INPUTS), .MAX_HITS(MAX_HITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vec       (in_vec),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_hit_num  (out_hit_num),
        .out_last     (out_last),
        .out_none     (out_none),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int num, input int last, input int none, input int ovf);
        beat_t b;
        b.idx = idx; b.num = num; b.last = last; b.none = none; b.ovf = ovf;
        exp_q.push_back(b);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_index"}, int'(out_index), 0);
        check({tag, "_out_hit_num"}, int'(out_hit_num), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
        check({tag, "_out_none"}, int'(out_none), 0);
        check({tag, "_out_overflow"}, int'(out_overflow), 0);
    endtask

    // Returns at the negedge after the accept edge, having checked one-cycle latency.
    task automatic send(input logic [INPUTS-1:0] v);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("send_wait_in_ready", int'(in_ready), 1);
        in_vec   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
        check("busy_in_ready", int'(in_ready), 0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_queue_left", exp_q.size(), 0);
    endtask

    // Compares the queue head on every valid cycle, so stalled beats are also checked for stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_ready_next) begin
                check("in_ready_after_last", int'(in_ready), 1);
                chk_ready_next = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_index", int'(out_index), -1);
                end else begin
                    check("beat_index", int'(out_index), exp_q[0].idx);
                    check("beat_hit_num", int'(out_hit_num), exp_q[0].num);
                    check("beat_last", int'(out_last), exp_q[0].last);
                    check("beat_none", int'(out_none), exp_q[0].none);
                    check("beat_overflow", int'(out_overflow), exp_q[0].ovf);
                    if (out_ready) begin
                        if (exp_q[0].last != 0) chk_ready_next = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d total=%0d", bad, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Three sparse hits
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        push(5, 0, 0, 0, 0); push(2, 1, 0, 0, 0); push(0, 2, 1, 0, 0);
`else
        push(0, 0, 0, 0, 0); push(2, 1, 0, 0, 0); push(5, 2, 1, 0, 0);
`endif
        send(12'h025);
        drain();

        // Empty vector gives a single none beat
        push(0, 0, 1, 1, 0);
        send(12'h000);
        drain();

        // All ones: capped at MAX_HITS with overflow on the last beat
        for (int k = 0; k < 7; k++) begin
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
            push(11 - k, k, (k == 6) ? 1 : 0, 0, (k == 6) ? 1 : 0);
`else
            push(k, k, (k == 6) ? 1 : 0, 0, (k == 6) ? 1 : 0);
`endif
        end
        send(12'hFFF);
        drain();

        // Stall on the first beat with stray in_valid pulses
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        push(11, 0, 0, 0, 0); push(4, 1, 1, 0, 0);
`else
        push(4, 0, 0, 0, 0); push(11, 1, 1, 0, 0);
`endif
        out_ready = 1'b0;
        send(12'h810);
        #1;
        in_vec   = 12'h001;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_queue_depth", exp_q.size(), 2);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        drain();

        // Reset mid-vector after two beats have been taken
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        push(7, 0, 0, 0, 0); push(6, 1, 0, 0, 0);
`else
        push(4, 0, 0, 0, 0); push(5, 1, 0, 0, 0);
`endif
        send(12'h0F0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_queue_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(1, 0, 1, 0, 0);
        send(12'h002);
        drain();

        @(posedge clk);
        #1;
        check_idle_outputs("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
